// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl
// Fetch sequencer for a 1024-word combinational instruction memory.
// Owns the program counter, presents the word index to memory, and captures
// each returned instruction with its PC into a 2-entry fetch buffer. The
// buffer head is handed to decode through a valid/ready handshake.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   imem_addr       word index {2'b00, pc[31:2]} to instruction memory
//   imem_inst       instruction returned combinationally for imem_addr
//   redirect_valid  load redirect_pc and flush the buffer
//   redirect_pc     byte-address redirect target
//   halt            stop issuing fetches; the buffer keeps draining
//   if_valid/if_ready/if_inst/if_pc  buffer head handshake to decode
//   fetch_fault     sticky misaligned-target fault (FETCH_MISALIGN_TRAP_EN only)
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect
// targets into a FAULT state that only reset leaves.

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic [31:0] if_pc,
  output logic        fetch_fault
`else
  output logic [31:0] if_pc
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, HALTED, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  // Entry 0 is always the head; a pop shifts entry 1 down.
  logic [31:0] e0_inst_q, e0_inst_d, e0_pc_q, e0_pc_d;
  logic [31:0] e1_inst_q, e1_inst_d, e1_pc_q, e1_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_q, fault_d;
  logic        misaligned;
`endif

  logic       pop;
  logic       redir;
  logic       enq;
  logic [1:0] base;

  assign if_valid  = (count_q != 2'd0);
  assign if_inst   = e0_inst_q;
  assign if_pc     = e0_pc_q;
  // Driven from the pc register alone, so no input reaches it combinationally.
  assign imem_addr = {2'b00, pc_q[31:2]};
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = fault_q;
`endif

  always_comb begin
    pop   = if_valid && if_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    redir = redirect_valid && (state_q != FAULT);
    misaligned = redir && (redirect_pc[1:0] != 2'b00);
`else
    redir = redirect_valid;
`endif
    enq   = (state_q == RUN) && !redir && !halt && ((count_q != 2'd2) || pop);
    base  = count_q - {1'b0, pop};

    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    e0_inst_d = e0_inst_q;
    e0_pc_d   = e0_pc_q;
    e1_inst_d = e1_inst_q;
    e1_pc_d   = e1_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d   = fault_q;
`endif

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = state_q;
    endcase

    if (pop) begin
      e0_inst_d = e1_inst_q;
      e0_pc_d   = e1_pc_q;
    end

    if (redir) begin
      count_d = 2'd0;
      pc_d    = redirect_pc & ~32'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misaligned) begin
        pc_d    = redirect_pc;
        fault_d = 1'b1;
        state_d = FAULT;
      end
`endif
    end else begin
      count_d = base + {1'b0, enq};
      if (enq) begin
        pc_d = pc_q + 32'd4;
        if (base == 2'd0) begin
          e0_inst_d = imem_inst;
          e0_pc_d   = pc_q;
        end else begin
          e1_inst_d = imem_inst;
          e1_pc_d   = pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      count_q   <= '0;
      e0_inst_q <= '0;
      e0_pc_q   <= '0;
      e1_inst_q <= '0;
      e1_pc_q   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      e0_inst_q <= e0_inst_d;
      e0_pc_q   <= e0_pc_d;
      e1_inst_q <= e1_inst_d;
      e1_pc_q   <= e1_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q   <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a 1024-word memory model.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  // Words 0..3 hold 0x11..0x44; every other word k holds 0xA000_0000 | k.
  function automatic logic [31:0] mem_word(input logic [9:0] k);
    if (k < 10'd4) return 32'h11 * ({22'd0, k} + 32'd1);
    return 32'hA000_0000 | {22'd0, k};
  endfunction

  assign imem_inst = mem_word(imem_addr[9:0]);

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
`ifdef FETCH_MISALIGN_TRAP_EN
    .if_pc(if_pc), .fetch_fault(fetch_fault)
`else
    .if_pc(if_pc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_inst"}, if_inst, inst);
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; if_ready = 1'b1;
    #2;
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;

    // Reset and stream
    step(); chk("idle_valid", {31'd0, if_valid}, 32'd0);
    step(); chk_head("s0", 32'h0, 32'h11);
    chk("s0_addr", imem_addr, 32'd1);
    step(); chk_head("s1", 32'h4, 32'h22);
    step(); chk_head("s2", 32'h8, 32'h33);
    step(); chk_head("s3", 32'hC, 32'h44);

    // Restart at 0, then backpressure
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(); chk("rd0_valid", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b0; if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk_head("bp", 32'h0, 32'h11);
    end
    chk("bp_addr", imem_addr, 32'd2);
    if_ready = 1'b1;
    step(); chk_head("bp_rel1", 32'h4, 32'h22);

    // Redirect with pop of pc 4
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step(); chk("rdp_valid", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b0;
    step(); chk_head("rdp_tgt", 32'h100, 32'hA000_0040);

    // Halt with two entries buffered
    if_ready = 1'b0;
    step(); chk_head("h_fill", 32'h100, 32'hA000_0040);
    halt = 1'b1; if_ready = 1'b1;
    step(); chk_head("h_drain", 32'h104, 32'hA000_0041);
    step(); chk("h_empty", {31'd0, if_valid}, 32'd0);
    chk("h_addr", imem_addr, 32'h42);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    step(); chk("h_rd_valid", {31'd0, if_valid}, 32'd0);
    chk("h_rd_addr", imem_addr, 32'h8);
    redirect_valid = 1'b0; halt = 1'b0;
    step(); chk("h_exit_valid", {31'd0, if_valid}, 32'd0);
    step(); chk_head("h_resume", 32'h20, 32'hA000_0008);

    // Memory index wrap and PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    step(); redirect_valid = 1'b0;
    step(); chk_head("w_1023", 32'hFFC, 32'hA000_03FF);
    step(); chk_head("w_1000", 32'h1000, 32'h11);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0;
    step(); chk_head("w_top", 32'hFFFF_FFFC, 32'hA000_03FF);
    step(); chk_head("w_zero", 32'h0, 32'h11);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    step(); chk("mis_valid0", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_addr", imem_addr, 32'h40);
    step(); chk("mis_valid1", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step(); redirect_valid = 1'b0;
    step(); chk("mis_ignored", {31'd0, if_valid}, 32'd0);
    chk("mis_fault_hold", {31'd0, fetch_fault}, 32'd1);
`else
    step(); chk_head("mis_clr", 32'h100, 32'hA000_0040);
    step(); chk_head("mis_next", 32'h104, 32'hA000_0041);
`endif

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_inst", if_inst, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("arst_fault", {31'd0, fetch_fault}, 32'd0);
`endif
    step(); #3 rst_n = 1'b1;
    step(); chk("rr_idle", {31'd0, if_valid}, 32'd0);
    step(); chk_head("rr_s0", 32'h0, 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
